// File: rtl/monoc_to_rgb888_if.sv
// Stream bundle between the binarizer, this expander and the display driver.
// The master drives the 1-bit pixel stream; the slave returns RGB888 and frame statistics.
interface monoc_to_rgb888_if;
  logic        pre_frame_vsync;
  logic        pre_frame_hsync;
  logic        pre_frame_de;
  logic        monoc;
  logic        monoc_fall;
  logic        post_frame_vsync;
  logic        post_frame_hsync;
  logic        post_frame_de;
  logic [23:0] post_rgb;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [19:0] white_cnt;
  logic        white_cnt_vld;
  logic        frame_err;

  modport master (
    output pre_frame_vsync, pre_frame_hsync, pre_frame_de, monoc, monoc_fall,
    input  post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb,
           pix_x, pix_y, white_cnt, white_cnt_vld, frame_err
  );

  modport slave (
    input  pre_frame_vsync, pre_frame_hsync, pre_frame_de, monoc, monoc_fall,
    output post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb,
           pix_x, pix_y, white_cnt, white_cnt_vld, frame_err
  );
endinterface

// File: rtl/monoc_to_rgb888.sv
// Expands the 1-bit monochrome stream to RGB888 (2-cycle latency), tracks pixel coordinates
// and reports per-frame white-pixel count and geometry error. Optional: MONOC_EDGE_HILITE_EN.
module monoc_to_rgb888 #(
  parameter int          H_ACT    = 640,
  parameter int          V_ACT    = 480,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000,
  parameter logic [23:0] HI_COLOR = 24'hFF0000
) (
  input  logic                  clk,
  input  logic                  rst,
  monoc_to_rgb888_if.slave      bus
);

  localparam logic [11:0] H_LAST = 12'(H_ACT - 1);
  localparam logic [11:0] V_CNT  = 12'(V_ACT);

  logic        r_vs1, r_hs1, r_de1, r_monoc1, r_fall1;
  logic [11:0] r_x1, r_y1, r_lines;
  logic [19:0] r_acc, r_wcnt1;
  logic        r_err, r_ferr1, r_close1, r_seen;

  logic        w_de_fall, w_vs_rise, w_line_bad, w_seen, w_white;
  logic [11:0] w_lines_tot;
  logic [19:0] w_acc_tot;

  assign w_de_fall   = r_de1 & ~bus.pre_frame_de;
  assign w_vs_rise   = bus.pre_frame_vsync & ~r_vs1;
  assign w_line_bad  = w_de_fall & (r_x1 != H_LAST);
  assign w_seen      = r_seen | bus.pre_frame_de;
  assign w_white     = bus.pre_frame_de & bus.monoc;
  assign w_lines_tot = (w_de_fall && r_lines != 12'hFFF) ? r_lines + 12'd1 : r_lines;
  assign w_acc_tot   = (w_white && r_acc != 20'hFFFFF) ? r_acc + 20'd1 : r_acc;

`ifdef MONOC_EDGE_HILITE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fall1 <= 1'b0;
    else     r_fall1 <= bus.monoc_fall;
  end
`else
  logic w_unused_fall;
  assign w_unused_fall = ^{bus.monoc_fall, HI_COLOR};
  assign r_fall1       = 1'b0;
`endif

  // Stage 1: register the stream, advance coordinates and the frame accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs1    <= 1'b0;
      r_hs1    <= 1'b0;
      r_de1    <= 1'b0;
      r_monoc1 <= 1'b0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_lines  <= '0;
      r_acc    <= '0;
      r_err    <= 1'b0;
      r_seen   <= 1'b0;
      r_close1 <= 1'b0;
      r_wcnt1  <= '0;
      r_ferr1  <= 1'b0;
    end else begin
      r_vs1    <= bus.pre_frame_vsync;
      r_hs1    <= bus.pre_frame_hsync;
      r_de1    <= bus.pre_frame_de;
      r_monoc1 <= bus.monoc;
      r_seen   <= w_seen;

      if (!bus.pre_frame_de || !r_de1) r_x1 <= '0;
      else if (r_x1 != 12'hFFF)        r_x1 <= r_x1 + 12'd1;

      if (w_vs_rise)                          r_y1 <= '0;
      else if (w_de_fall && r_y1 != 12'hFFF)  r_y1 <= r_y1 + 12'd1;

      // A line ending in the vsync-rise cycle is folded into the frame being closed.
      if (w_vs_rise) begin
        r_close1 <= w_seen;
        if (w_seen) begin
          r_wcnt1 <= w_acc_tot;
          r_ferr1 <= r_err | w_line_bad | (w_lines_tot != V_CNT);
        end
        r_acc   <= '0;
        r_lines <= '0;
        r_err   <= 1'b0;
      end else begin
        r_close1 <= 1'b0;
        r_acc    <= w_acc_tot;
        r_lines  <= w_lines_tot;
        r_err    <= r_err | w_line_bad;
      end
    end
  end

  // Stage 2: colour selection and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.post_frame_vsync <= 1'b0;
      bus.post_frame_hsync <= 1'b0;
      bus.post_frame_de    <= 1'b0;
      bus.post_rgb         <= '0;
      bus.pix_x            <= '0;
      bus.pix_y            <= '0;
      bus.white_cnt        <= '0;
      bus.white_cnt_vld    <= 1'b0;
      bus.frame_err        <= 1'b0;
    end else begin
      bus.post_frame_vsync <= r_vs1;
      bus.post_frame_hsync <= r_hs1;
      bus.post_frame_de    <= r_de1;
      bus.pix_x            <= r_x1;
      bus.pix_y            <= r_y1;
      bus.white_cnt_vld    <= r_close1;
      if (!r_de1)       bus.post_rgb <= 24'h0;
      else if (r_fall1) bus.post_rgb <= HI_COLOR;
      else if (r_monoc1) bus.post_rgb <= FG_COLOR;
      else              bus.post_rgb <= BG_COLOR;
      if (r_close1) begin
        bus.white_cnt <= r_wcnt1;
        bus.frame_err <= r_ferr1;
      end
    end
  end

endmodule
